uart_tx_fifo: RTL
=================

# uart_tx_fifo

Byte-wide transmit FIFO and frame sequencer that sits directly upstream of `uart_transmitter`. It buffers bytes written by the host, then presents one byte at a time on `tx_data` (wired to the transmitter's `data_in`) with a single-cycle `tx_start` pulse. It holds that byte stable for the full frame, so the transmitter's start-state and parity-state loads both see the same value.

## Interface
- `DEPTH`, 8, FIFO entries; power of two, ≥2
- `ADDR_W`, 3, log2(DEPTH)
- `FRAME_CYCLES`, 11, hold cycles after `tx_start` (start + 8 data + parity + stop); must be ≥11
- `clock`  in  1  rising-edge clock, same clock as the transmitter
- `piso_reset`  in  1  asynchronous, active-low reset, shared with the transmitter
- `wr_en`  in  1  host write strobe, sampled on `clock`
- `wr_data`  in  8  host byte
- `full`  out  1  FIFO holds DEPTH entries
- `empty`  out  1  FIFO holds 0 entries
- `level`  out  ADDR_W+1  current occupancy, 0..DEPTH
- `tx_data`  out  8  byte under transmission; drives `uart_transmitter.data_in`
- `tx_start`  out  1  one-cycle start request; drives `uart_transmitter.tx_start`
- `tx_busy`  out  1  sequencer is not in IDLE
- `ovf_clr`  in  1  clears `overflow` (used only when the feature is enabled)
- `overflow`  out  1  sticky write-while-full flag

## Operation
- Storage: DEPTH×8 array with `wr_ptr` and `rd_ptr` of ADDR_W bits, each wrapping modulo DEPTH. `level` is a separate counter.
  - `full` = (level==DEPTH); `empty` = (level==0).
- Write: when `wr_en` is high and `full` is low, `mem[wr_ptr]` ← `wr_data` and `wr_ptr` increments.
  - When `wr_en` is high and `full` is high, the byte is dropped. No pointer or level change.
- Pop: an internal event occurring when the sequencer is in IDLE and `empty` is low.
  - `tx_data` ← `mem[rd_ptr]`, `rd_ptr` increments.
- Level update per edge: +1 on write only, −1 on pop only, unchanged when both or neither occur.
  - Write and pop in the same cycle are legal at any non-full level.
- Sequencer states:
  - IDLE: `tx_start`=0. On a pop, go to START.
  - START: `tx_start`=1 for exactly this cycle; load `hold_cnt` ← FRAME_CYCLES; go to HOLD.
  - HOLD: `tx_start`=0. Decrement `hold_cnt` each cycle; when `hold_cnt`==1, go to IDLE.
- `tx_busy` = (state != IDLE).
- `tx_data` changes only at a pop edge, which is always while the transmitter is idle. It is stable from START through the transmitter's stop state.
- Reset values: `tx_data`=8'h00, `tx_start`=0, `tx_busy`=0, `full`=0, `empty`=1, `level`=0, `overflow`=0, pointers=0, state=IDLE.
- Reset mid-frame aborts the frame and discards all FIFO contents. The transmitter is reset by the same signal.

## Timing
- No fall-through. A byte written at edge N pops at edge N+1 at the earliest, if the sequencer is IDLE.
  - START is the cycle after the pop edge.
  - The transmitter enters start_bit on the edge that ends START.
- Per-byte period with back-to-back data: 1 (IDLE/pop) + 1 (START) + FRAME_CYCLES = 13 cycles at the default.
- The transmitter returns to idle exactly as HOLD ends, so the next pop never overlaps a frame.
- `full`, `empty` and `level` are registered and reflect the edge just taken.
- `overflow` sets on the edge of a dropped write. `ovf_clr` clears it on the next edge.
  - If `ovf_clr` and a dropped write occur in the same cycle, set wins.

## Configuration
- Macro: `UART_TX_FIFO_OVF_EN`.
- Defined: the sticky `overflow` register and the `ovf_clr` input are functional.
- Undefined:
  - `overflow` is tied to 0 and `ovf_clr` is ignored.
  - Writes while full are still silently dropped.
  - No overflow register is synthesized.

## Structure
- Shared package `uart_pkg` holds:
  - `UART_FRAME_CYCLES` = 11.
  - The sequencer state encoding (IDLE=2'b00, START=2'b01, HOLD=2'b10).
  - The byte width constant 8.
- One sub-module, `tx_fifo_ram`: DEPTH×8 storage with synchronous write and asynchronous read at `rd_ptr`.
- Pointers, level, sequencer and flags live in `uart_tx_fifo`.

## Test plan
- Reset then write 8'h5B once -> one `tx_start` pulse 2 cycles after the write edge; `tx_data`=8'h5B for 12 cycles; transmitter serial line shows 0, 1,1,0,1,1,0,1,0, parity 1, stop 1.
- Write 3 bytes back-to-back (8'hA1, 8'h02, 8'hFF) -> `tx_start` pulses exactly 13 cycles apart, in order; `empty`=1 after the third pop; `tx_busy` low only in IDLE cycles.
- Write 9 bytes with no pop possible (during a frame) -> `full`=1 at `level`=8; 9th byte dropped; `overflow`=1 (macro on) or 0 (macro off); `ovf_clr` pulse clears it.
- Write while a pop occurs at `level`=3 -> `level` stays 3; popped byte correct; written byte emitted later in order.
- Write 20 bytes over time across pointer wrap -> output order matches input order; no loss while never full.
- Assert `piso_reset` during HOLD with 4 bytes queued -> all outputs at reset values the same cycle; no further `tx_start` until new writes.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART constants: byte width, frame hold length and sequencer state encoding.
// Latency: n/a (constants only).
// Backpressure: n/a.
package uart_pkg;

    localparam int UART_DATA_W       = 8;
    localparam int UART_FRAME_CYCLES = 11;

    // Sequencer states, kept as plain constants so legacy code can compare against them
    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_START = 2'b01;
    localparam logic [1:0] ST_HOLD  = 2'b10;

endpackage

// File: rtl/tx_fifo_ram.sv
// DEPTH x 8 byte storage for the transmit FIFO; synchronous write, asynchronous read.
// Latency: write visible on the read port the cycle after the write edge.
// Backpressure: none; the caller guards writes with its own full flag.
module tx_fifo_ram
    import uart_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic                   clock,
    input  logic                   we_i,
    input  logic [ADDR_W-1:0]      waddr_i,
    input  logic [UART_DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0]      raddr_i,
    output logic [UART_DATA_W-1:0] rdata_o
);

    logic [UART_DATA_W-1:0] mem_q [DEPTH];

    // Storage is not reset: stale entries are unreachable once the pointers are cleared
    always_ff @(posedge clock) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_tx_fifo.sv
// Transmit FIFO + frame sequencer: buffers host bytes and hands them one at a time to uart_transmitter.
// Latency: byte written at edge N pops at N+1 at the earliest; tx_start follows one cycle later; 13-cycle byte period.
// Backpressure: writes while full are dropped; with UART_TX_FIFO_OVF_EN defined a sticky overflow flag records it.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH        = 8,
    parameter int ADDR_W       = 3,
    parameter int FRAME_CYCLES = UART_FRAME_CYCLES
) (
    input  logic                   clock,
    input  logic                   piso_reset,
    input  logic                   wr_en,
    input  logic [UART_DATA_W-1:0] wr_data,
    output logic                   full,
    output logic                   empty,
    output logic [ADDR_W:0]        level,
    output logic [UART_DATA_W-1:0] tx_data,
    output logic                   tx_start,
    output logic                   tx_busy,
    input  logic                   ovf_clr,
    output logic                   overflow
);

    localparam int CNT_W = $clog2(FRAME_CYCLES + 1);
    localparam logic [ADDR_W:0] LVL_FULL = (ADDR_W + 1)'(DEPTH);

    logic [ADDR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]        level_q, level_d;
    logic [1:0]             state_q, state_d;
    logic [CNT_W-1:0]       hold_cnt_q, hold_cnt_d;
    logic [UART_DATA_W-1:0] tx_data_q, tx_data_d;
    logic [UART_DATA_W-1:0] rd_data;
    logic                   wr_ok;
    logic                   pop;

    tx_fifo_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clock   (clock),
        .we_i    (wr_ok),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_data),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_data)
    );

    assign full     = (level_q == LVL_FULL);
    assign empty    = (level_q == '0);
    assign level    = level_q;
    assign tx_data  = tx_data_q;
    assign tx_start = (state_q == ST_START);
    assign tx_busy  = (state_q != ST_IDLE);

    // Accepted write and pop events; full is the pre-edge value, so a pop cannot make room for a same-cycle write
    always_comb begin
        wr_ok = wr_en && !full;
        pop   = (state_q == ST_IDLE) && !empty;
    end

    // Pointer, occupancy and output-byte next state
    always_comb begin
        wr_ptr_d  = wr_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d  = pop   ? rd_ptr_q + 1'b1 : rd_ptr_q;
        tx_data_d = pop   ? rd_data         : tx_data_q;
        level_d   = level_q;
        case ({wr_ok, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    // Frame sequencer: one START cycle, then FRAME_CYCLES of HOLD while the transmitter shifts
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (pop) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                hold_cnt_d = CNT_W'(FRAME_CYCLES);
                state_d    = ST_HOLD;
            end
            ST_HOLD: begin
                hold_cnt_d = hold_cnt_q - 1'b1;
                if (hold_cnt_q == CNT_W'(1)) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset drops any frame in flight and empties the FIFO
    always_ff @(posedge clock or negedge piso_reset) begin
        if (!piso_reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            state_q    <= ST_IDLE;
            hold_cnt_q <= '0;
            tx_data_q  <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            tx_data_q  <= tx_data_d;
        end
    end

`ifdef UART_TX_FIFO_OVF_EN
    logic overflow_q, overflow_d;

    // Sticky drop flag; a drop in the same cycle as a clear keeps it set
    always_comb begin
        overflow_d = overflow_q;
        if (wr_en && full) begin
            overflow_d = 1'b1;
        end else if (ovf_clr) begin
            overflow_d = 1'b0;
        end
    end

    // Overflow register
    always_ff @(posedge clock or negedge piso_reset) begin
        if (!piso_reset) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    assign overflow = overflow_q;
`else
    logic unused_ovf_clr;

    assign unused_ovf_clr = ovf_clr;
    assign overflow       = 1'b0;
`endif

endmodule
